// File: rtl/tt06_sar_pkg.sv
// tt06_sar_pkg: shared FSM state encoding and ui_in pin indices for the SAR ADC controller
package tt06_sar_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SAMPLE = 2'd1, CONVERT = 2'd2, DONE = 2'd3} state_e;
   localparam int NBITS_DEFAULT = 8;
   localparam int START = 0;
   localparam int CMP = 1;
   localparam int SEL = 2;
endpackage

// File: rtl/tt_um_tt06_sar_wulffern_sar_logic.sv
// sar_logic: SAR conversion FSM, trial-code accumulator, bit pointer and result register
module sar_logic
   import tt06_sar_pkg::*;
#(
   parameter int NBITS = NBITS_DEFAULT,
   parameter int SAMPLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena_i,
   input  logic             start_i,
   input  logic             cmp_i,
   output logic [1:0]       state_o,
   output logic [2:0]       bit_idx_o,
   output logic             toggle_o,
   output logic             done_o,
   output logic [NBITS-1:0] result_o,
   output logic [NBITS-1:0] trial_o
);
   state_e           state_q;
   logic [NBITS-1:0] acc_q, result_q, mask, acc_d;
   logic [2:0]       bit_idx_q;
   logic [3:0]       cnt_q;
   logic             done_q, toggle_q;

   assign mask  = NBITS'(1) << bit_idx_q;
   assign acc_d = cmp_i ? (acc_q | mask) : (acc_q & ~mask);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         result_q  <= '0;
         bit_idx_q <= 3'(NBITS - 1);
         cnt_q     <= '0;
         done_q    <= 1'b0;
         toggle_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!ena_i) state_q <= IDLE;
         else case (state_q)
            IDLE: if (start_i) begin
               state_q <= SAMPLE;
               cnt_q   <= '0;
            end
            SAMPLE: begin
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'(SAMPLE_CYCLES - 1)) begin
                  state_q   <= CONVERT;
                  acc_q     <= '0;
                  bit_idx_q <= 3'(NBITS - 1);
               end
            end
            CONVERT: begin
               acc_q     <= acc_d;
               bit_idx_q <= bit_idx_q - 3'd1;
               // the last decision goes straight into result so it is valid on DONE entry
               if (bit_idx_q == 3'd0) begin
                  state_q  <= DONE;
                  result_q <= acc_d;
                  toggle_q <= ~toggle_q;
                  done_q   <= 1'b1;
               end
            end
            DONE: begin
               state_q <= start_i ? SAMPLE : IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign state_o   = state_q;
   assign bit_idx_o = bit_idx_q;
   assign toggle_o  = toggle_q;
   assign done_o    = done_q;
   assign result_o  = result_q;
   assign trial_o   = (state_q == CONVERT) ? (acc_q | mask) : '0;
endmodule

// File: rtl/tt_um_tt06_sar_wulffern.sv
// tt_um_tt06_sar_wulffern: TinyTapeout tile wrapper for the 8-bit SAR ADC controller
module tt_um_tt06_sar_wulffern
   import tt06_sar_pkg::*;
#(
   parameter int NBITS = NBITS_DEFAULT,
   parameter int SAMPLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);
   logic [1:0]       state;
   logic [2:0]       bit_idx;
   logic             toggle, done, busy, unused_ok;
   logic [NBITS-1:0] result, trial;
   logic [7:0]       status;

   sar_logic #(.NBITS(NBITS), .SAMPLE_CYCLES(SAMPLE_CYCLES)) u_sar (
      .clk      (clk),
      .rst      (rst),
      .ena_i    (ena),
      .start_i  (ui_in[START]),
      .cmp_i    (ui_in[CMP]),
      .state_o  (state),
      .bit_idx_o(bit_idx),
      .toggle_o (toggle),
      .done_o   (done),
      .result_o (result),
      .trial_o  (trial)
   );

   assign busy      = (state == SAMPLE) | (state == CONVERT);
   assign status    = {done, busy, state, toggle, bit_idx};
   assign uo_out    = ui_in[SEL] ? status : 8'(result);
   assign uio_out   = 8'(trial);
   assign uio_oe    = 8'hFF;
   assign unused_ok = &{1'b0, uio_in, ui_in[7:3]};
endmodule

// File: tb/tb_tt_um_tt06_sar_wulffern.sv
// tb_tt_um_tt06_sar_wulffern: directed and random conversions against an ideal binary-search ADC model
module tb_tt_um_tt06_sar_wulffern;
   logic       clk = 1'b0;
   logic       rst, ena, start, sel;
   logic [7:0] vin, ui_in, uo_out, uio_in, uio_out, uio_oe;
   logic       tog = 1'b0;
   logic [7:0] last_res = 8'h00;
   int         checks = 0, failures = 0;
   logic [7:0] dir [4] = '{8'hFF, 8'h00, 8'h5A, 8'hA5};

   // ideal comparator: analog input vs. the DAC trial code
   assign ui_in = {5'b0, sel, (vin >= uio_out), start};

   always #125 clk = ~clk;

   tt_um_tt06_sar_wulffern dut (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .ui_in  (ui_in),
      .uo_out (uo_out),
      .uio_in (uio_in),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic stat(input string tag, input logic [4:0] exp);
      sel = 1'b1;
      #1;
      chk(tag, uo_out & 8'hF8, {exp, 3'b000});
      sel = 1'b0;
      #1;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic enter_sample;
      step();
      stat("sample_status", {1'b0, 1'b1, 2'b01, tog});
      chk("sample_dac", uio_out, 8'h00);
   endtask

   // from SAMPLE: expects trial codes of a binary search for v, then v in DONE
   task automatic conv(input logic [7:0] v, input int drop_at);
      logic [7:0] e;
      vin = v;
      step();
      for (int k = 7; k >= 0; k--) begin
         e = ((v >> (k + 1)) << (k + 1)) | (8'd1 << k);
         chk("trial", uio_out, e);
         if (k == drop_at) start = 1'b0;
         step();
      end
      tog = ~tog;
      last_res = v;
      chk("result", uo_out, v);
      stat("done_status", {1'b1, 1'b0, 2'b11, tog});
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1; start = 1'b0; sel = 1'b0; vin = 8'h00;
      uio_in = 8'($urandom);
      repeat (2) step();
      chk("rst_result", uo_out, 8'h00);
      chk("rst_dac", uio_out, 8'h00);
      chk("rst_oe", uio_oe, 8'hFF);
      sel = 1'b1;
      #1;
      chk("rst_status", uo_out, 8'h07);
      sel = 1'b0;
      rst = 1'b0;
      step();
      stat("idle_status", 5'b0);
      chk("idle_dac", uio_out, 8'h00);
      start = 1'b1;
      foreach (dir[i]) begin
         enter_sample();
         conv(dir[i], -1);
      end
      for (int i = 0; i < 4; i++) begin
         enter_sample();
         conv(8'($urandom), -1);
      end
      // start released mid-conversion: finishes, then parks in IDLE
      enter_sample();
      conv(8'($urandom), 4);
      step();
      stat("idle_after_drop", {4'b0, tog});
      chk("idle_drop_dac", uio_out, 8'h00);
      step();
      stat("idle_stays", {4'b0, tog});
      // ena low during CONVERT discards the conversion
      start = 1'b1;
      enter_sample();
      vin = 8'h33;
      step();
      chk("abort_trial", uio_out, 8'h80);
      step();
      step();
      ena = 1'b0;
      step();
      stat("abort_status", {4'b0, tog});
      chk("abort_result", uo_out, last_res);
      chk("abort_dac", uio_out, 8'h00);
      ena = 1'b1;
      enter_sample();
      conv(8'($urandom), -1);
      // reset during CONVERT
      enter_sample();
      vin = 8'hC3;
      step();
      step();
      rst = 1'b1;
      step();
      chk("rstc_result", uo_out, 8'h00);
      chk("rstc_dac", uio_out, 8'h00);
      chk("rstc_oe", uio_oe, 8'hFF);
      sel = 1'b1;
      #1;
      chk("rstc_status", uo_out, 8'h07);
      sel = 1'b0;
      rst = 1'b0;
      start = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
